// File: rtl/bcd_scan_driver_if.sv
// Control/display bundle between a value source and the BCD scan driver.
// The source drives bin/load/blank_en; the driver returns status and scan outputs.
interface bcd_scan_driver_if #(
    parameter int BIN_W = 14
) ();
    logic [BIN_W-1:0] bin;
    logic             load;
    logic             blank_en;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [3:0]       dig;
    logic [3:0]       an;

    modport master (
        output bin, load, blank_en,
        input  busy, done, ovf, dig, an
    );

    modport slave (
        input  bin, load, blank_en,
        output busy, done, ovf, dig, an
    );
endinterface

// File: rtl/bcd_scan_driver.sv
// Binary-to-BCD converter (iterative double-dabble) feeding a 4-digit
// time-multiplexed seven-segment scan with optional leading-zero blanking.
module bcd_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BIN_W       = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    bcd_scan_driver_if.slave  sd
);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic {IDLE, CONV} state_t;

    state_t           state;
    logic [BIN_W-1:0] bin_sr;
    logic [15:0]      bcd;
    logic [3:0]       iter;
    logic [15:0]      disp;
    logic             busy_q;
    logic             done_q;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;

    logic             over;
    logic [BIN_W-1:0] clamped;
    logic [15:0]      adj;
    logic [29:0]      next_sr;
    logic [3:0]       lead;
    logic [3:0]       lit;
    logic [3:0]       sel;

    assign over    = (sd.bin > BIN_W'(9999));
    assign clamped = over ? BIN_W'(9999) : sd.bin;

    always_comb begin
        adj = bcd;
        for (int unsigned n = 0; n < 4; n++) begin
            if (bcd[n*4 +: 4] >= 4'd5)
                adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
        end
    end

    // One double-dabble step: add-3 correction, then shift BCD:binary left.
    assign next_sr = {adj[14:0], bin_sr, 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            bin_sr <= '0;
            bcd    <= '0;
            iter   <= '0;
            disp   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (sd.load) begin
                        state  <= CONV;
                        busy_q <= 1'b1;
                        ovf_q  <= over;
                        bin_sr <= clamped;
                        bcd    <= '0;
                        iter   <= '0;
                    end
                end
                CONV: begin
                    bcd    <= next_sr[29:14];
                    bin_sr <= next_sr[13:0];
                    iter   <= iter + 4'd1;
                    if (iter == 4'd13) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        disp   <= next_sr[29:14];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // lead[p]: some digit at position p or above is non-zero; ones always lit.
    assign lead[3] = |disp[15:12];
    assign lead[2] = lead[3] | (|disp[11:8]);
    assign lead[1] = lead[2] | (|disp[7:4]);
    assign lead[0] = 1'b1;
    assign lit     = sd.blank_en ? lead : 4'b1111;
    assign sel     = 4'b0001 << idx;

    assign sd.dig  = disp[{idx, 2'b00} +: 4];
    assign sd.an   = ~(sel & lit);
    assign sd.busy = busy_q;
    assign sd.done = done_q;
    assign sd.ovf  = ovf_q;
endmodule
